seq_nibble_adder: RTL
=====================

// Module: seq_nibble_adder
// PURPOSE
//  Multi-cycle adder controller: adds two NUM_NIBBLES*4-bit operands with one shared 4-bit ripple adder.
//  Processes one nibble per clock, LSB first, and chains the carry through a register.
//  Sits between a requester (start/done handshake) and the adder_4bit datapath slice.
//  Trades latency for area in the wide-add paths.
// PARAMETERS
//  NUM_NIBBLES  default 4   number of 4-bit slices per operand; WIDTH = 4*NUM_NIBBLES (legal range 2..16)
// PORTS
//  clk        in   1      system clock, rising edge
//  n_rst      in   1      asynchronous active-low reset
//  start      in   1      request; sampled only in IDLE or DONE
//  op_a       in   WIDTH  operand A, captured on accepted start
//  op_b       in   WIDTH  operand B, captured on accepted start
//  carry_in   in   1      initial carry, captured on accepted start
//  busy       out  1      high while in ADD state
//  done       out  1      one-cycle pulse: result valid
//  sum        out  WIDTH  result, registered, held until the next accepted start
//  carry_out  out  1      final carry, registered, held with sum
// BEHAVIOUR
//  - Reset values: state=IDLE, busy=0, done=0, sum=0, carry_out=0, nibble index=0, op regs=0.
//  - FSM states:
//    - IDLE: start=1 -> capture op_a, op_b, carry_in; clear sum; idx=0; go to ADD.
//    - ADD: each cycle, feed nibble idx of A and B plus the carry register to the adder.
//      - Write the adder sum into sum[4*idx+3:4*idx]; the adder carry-out goes into the carry register; idx++.
//      - When idx==NUM_NIBBLES-1: go to DONE and load carry_out from the adder carry-out.
//    - DONE: done=1 for exactly this cycle.
//      - start=1 -> accepted as in IDLE (back-to-back) -> ADD.
//      - Otherwise -> IDLE.
//  - Latency: start accepted at edge E0; done high in the cycle after edge E(NUM_NIBBLES).
//    - That is NUM_NIBBLES+1 cycles from the start cycle to the done cycle.
//  - start during ADD is ignored; it is neither queued nor applied to in-flight operands.
//  - Inputs op_a, op_b and carry_in may change freely after acceptance; only the captured copies are used.
//  - Arithmetic is unsigned modulo 2^WIDTH; the carry out of the top nibble is carry_out. No saturation.
//  - Partial sum bits are visible during ADD but are only defined as valid in the done cycle and afterwards.
//  - n_rst low mid-operation: immediate return to reset values. The in-flight result is discarded and no done is issued.
//  - The index counter is $clog2(NUM_NIBBLES) bits wide. It never wraps past NUM_NIBBLES-1 and resets to 0 on each accept.
// CONFIGURATION
//  Macro SEQ_NIBBLE_ADDER_SUB_EN:
//  - Defined: adds input port 'subtract' (1 bit), captured with the operands.
//    - When captured high, B is inverted before use and the initial carry is forced to 1, so sum = A - B.
//    - carry_out=1 means no borrow (A >= B); carry_in is ignored.
//  - Undefined: no subtract port; add-only behaviour as above.
// STRUCTURE
//  - Package seq_nibble_adder_pkg:
//    - typedef enum logic [1:0] {IDLE, ADD, DONE} seq_add_state_t
//    - localparam NIBBLE_W = 4
//  - Sub-module: exactly one adder_4bit instance (u_slice), driven by the nibble mux and the carry register.
//  - Next-state logic and output logic are combinational. State, index, operands, carry and sum are held in flops.
// TESTING (NUM_NIBBLES=4)
//  - Reset: n_rst=0 -> busy=0, done=0, sum=16'h0000, carry_out=0.
//  - Basic add: start with A=16'h1234, B=16'h4321, cin=0 -> busy high for 4 cycles, then done pulse.
//    - sum=16'h5555, carry_out=0.
//  - Ripple carry: A=16'hFFFF, B=16'h0000, cin=1 -> sum=16'h0000, carry_out=1. Also A=16'h8000, B=16'h8000 -> sum=0, carry_out=1.
//  - Ignored start: start pulsed at cycle 2 of ADD with A=B=16'h1111 -> result unaffected, exactly one done pulse.
//    - Back-to-back start in the DONE cycle -> second result after a further 5 cycles.
//  - Reset mid-op: n_rst low at ADD cycle 2 -> no done; sum=0; a subsequent add of 16'h0001+16'h0001 gives 16'h0002.
//  - SUB_EN build: A=16'h0005, B=16'h0007, subtract=1 -> sum=16'hFFFE, carry_out=0.
//    - A=16'h0007, B=16'h0005 -> sum=16'h0002, carry_out=1.

Source files
------------

// File: rtl/seq_nibble_adder_pkg.sv
// Shared types for the sequential nibble adder: FSM state encoding and nibble width.
// Optional subtract support is enabled by the SEQ_NIBBLE_ADDER_SUB_EN macro in the top.
`timescale 1ns/1ps
package seq_nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } seq_add_state_t;

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit ripple adder slice shared by every nibble of a wide add.
`timescale 1ns/1ps
module adder_4bit
  import seq_nibble_adder_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t sum,
  output logic    cout
);

  logic [NIBBLE_W:0] total;

  assign total = (NIBBLE_W+1)'(a) + (NIBBLE_W+1)'(b) + (NIBBLE_W+1)'(cin);
  assign sum   = total[NIBBLE_W-1:0];
  assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/seq_nibble_adder.sv
// Multi-cycle adder: one shared 4-bit slice processes a nibble per clock, LSB first.
// Define SEQ_NIBBLE_ADDER_SUB_EN to add a 'subtract' input (sum = A - B, carry_out = no borrow).
`timescale 1ns/1ps
module seq_nibble_adder
  import seq_nibble_adder_pkg::*;
#(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            start,
  input  logic [NIBBLE_W*NUM_NIBBLES-1:0] op_a,
  input  logic [NIBBLE_W*NUM_NIBBLES-1:0] op_b,
  input  logic                            carry_in,
`ifdef SEQ_NIBBLE_ADDER_SUB_EN
  input  logic                            subtract,
`endif
  output logic                            busy,
  output logic                            done,
  output logic [NIBBLE_W*NUM_NIBBLES-1:0] sum,
  output logic                            carry_out
);

  localparam int IDX_W = $clog2(NUM_NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  seq_add_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_NIBBLES-1:0][NIBBLE_W-1:0] a_q, a_d;
  logic [NUM_NIBBLES-1:0][NIBBLE_W-1:0] b_q, b_d;
  logic [NUM_NIBBLES-1:0][NIBBLE_W-1:0] sum_q, sum_d;
  logic carry_q, carry_d;
  logic cout_q, cout_d;

  nibble_t slice_sum;
  logic    slice_cout;
  logic    accept;

  adder_4bit u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Captured operands for a new request; subtraction is folded into B and the carry here
  // so the datapath below never needs to know which operation is in flight.
  logic [NIBBLE_W*NUM_NIBBLES-1:0] cap_b;
  logic                            cap_cin;

`ifdef SEQ_NIBBLE_ADDER_SUB_EN
  assign cap_b   = subtract ? ~op_b : op_b;
  assign cap_cin = subtract ? 1'b1  : carry_in;
`else
  assign cap_b   = op_b;
  assign cap_cin = carry_in;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        accept = start;
      end
      ADD: begin
        sum_d[idx_q] = slice_sum;
        carry_d      = slice_cout;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cout_d  = slice_cout;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        accept  = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = ADD;
      idx_d   = '0;
      a_d     = op_a;
      b_d     = cap_b;
      carry_d = cap_cin;
      sum_d   = '0;
      cout_d  = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q == ADD);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule
